// File: rtl/ula_driver.sv
// rtl/ula_driver.sv - command FIFO and issue/response sequencer for the combinational ula
// Holds the last captured result in acc so commands can chain on it.
module ula_driver #(
  parameter int N     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_op,
  input  logic [N-1:0] cmd_a,
  input  logic [N-1:0] cmd_b,
  input  logic         cmd_acc,
  output logic [2:0]   ula_op,
  output logic [N-1:0] ula_a,
  output logic [N-1:0] ula_b,
  input  logic [N-1:0] ula_r,
  input  logic         ula_zero,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [N-1:0] res_r,
  output logic         res_zero,
  output logic [N-1:0] acc,
  output logic         busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 3 + 2 * N + 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t          state;
  logic [EW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic [2:0]      e_op;
  logic [N-1:0]    e_a;
  logic [N-1:0]    e_b;
  logic            e_acc;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  // Pops look only at the registered count, so a fresh push is seen a cycle later.
  assign pop       = !empty && ((state == IDLE) || ((state == RESP) && res_ready));
  assign busy      = (state != IDLE) || !empty;

  assign {e_op, e_a, e_b, e_acc} = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {cmd_op, cmd_a, cmd_b, cmd_acc};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ula_op    <= 3'b111;
      ula_a     <= '0;
      ula_b     <= '0;
      res_valid <= 1'b0;
      res_r     <= '0;
      res_zero  <= 1'b0;
      acc       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            ula_op <= e_op;
            ula_a  <= e_acc ? acc : e_a;
            ula_b  <= e_b;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          res_r     <= ula_r;
          res_zero  <= ula_zero;
          acc       <= ula_r;
          res_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            if (pop) begin
              ula_op <= e_op;
              ula_a  <= e_acc ? acc : e_a;
              ula_b  <= e_b;
              state  <= ISSUE;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
